// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared constants and state type for the fetch front end.
// Exports XLEN, NOP_INSTR, PC_STEP and fetch_state_t {IDLE, FETCH, DRAIN}.
package rv_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with flush; head is read combinationally.
// Ports: clk, rst_n, flush, push/push_data, pop, head, empty, count.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic full;
  logic wr;
  logic rd;

  assign empty = (count == '0);
  assign full = (count == CW'(DEPTH));
  assign head = mem[rp];
  assign wr = push && !flush;
  assign rd = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= push_data;
  end

  // A full queue may only accept a push in the same cycle as a pop.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (!full || pop)
  );
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential fetch, in-order response queue, redirect/drain.
// Ports: imem_req_*/imem_rsp_* to memory, dec_* to decode, redirect/redirect_pc.
// Optional IF_BYPASS_EN: forward a response straight to decode when queue empty.
module instr_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  fetch_state_t state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] last_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] out_next;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] q_count;
  logic [CW-1:0] t_count;
  logic [2*XLEN-1:0] q_head;
  logic [XLEN-1:0] t_head;
  logic q_empty;
  logic t_empty;
  logic req_fire;
  logic rsp_live;
  logic bypass;
  logic q_push;
  logic q_pop;

  assign imem_req_valid = (state != IDLE) && !redirect &&
    (({1'b0, q_count} + {1'b0, outstanding}) < CREDITS);
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  // Responses are stale while drop>0, and the one racing a redirect is too.
  assign rsp_live = imem_rsp_valid && (drop == '0) && !redirect;

`ifdef IF_BYPASS_EN
  assign bypass = rsp_live && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign q_push = rsp_live && !(bypass && dec_ready);
  assign q_pop = !q_empty && dec_ready;
  assign dec_valid = !q_empty || bypass;

  always_comb begin
    dec_instr = NOP_INSTR;
    dec_pc = last_pc;
    if (!q_empty) begin
      {dec_instr, dec_pc} = q_head;
    end else if (bypass) begin
      dec_instr = imem_rsp_data;
      dec_pc = t_head;
    end
  end

  assign out_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  always_comb begin
    drop_next = drop;
    if (redirect) drop_next = out_next;
    else if (imem_rsp_valid && drop != '0) drop_next = drop - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      last_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
    end else begin
      last_pc <= dec_pc;
      outstanding <= out_next;
      drop <= drop_next;
      if (redirect) fetch_pc <= redirect_pc & ~32'h3;
      else if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: if (redirect && drop_next != '0) state <= DRAIN;
        DRAIN: if (!redirect && drop_next == '0) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  instr_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect),
    .push(req_fire),
    .push_data(fetch_pc),
    .pop(rsp_live),
    .head(t_head),
    .empty(t_empty),
    .count(t_count)
  );

  instr_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_q (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect),
    .push(q_push),
    .push_data({imem_rsp_data, t_head}),
    .pop(q_pop),
    .head(q_head),
    .empty(q_empty),
    .count(q_count)
  );

  // Every live response must find its request PC waiting.
  a_tag_avail: assert property (
    @(posedge clk) disable iff (!rst_n) rsp_live |-> !t_empty
  );
  a_tag_bound: assert property (
    @(posedge clk) disable iff (!rst_n) t_count <= outstanding
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scoreboard bench for instr_fetch_queue.
// In-order memory model with variable latency; monitor compares decode output.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef IF_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid;
  logic [31:0] imem_req_addr;
  logic imem_req_ready = 1'b1;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic dec_ready = 1'b1;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
    .dec_ready(dec_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int tag;
  } req_t;

  req_t pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_q[$];
  int cyc = 0;
  int lat = 1;
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_fire = 0;
  int first_acc = -1;
  int first_dv = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A00_00A5;
  endfunction

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  // Monitor: samples mid-cycle, logs accepts, scores decode handshakes.
  always @(negedge clk) begin : mon
    logic [31:0] pc;
    cyc++;
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc});
        acc_log.push_back(imem_req_addr);
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (dec_valid && first_dv < 0) first_dv = cyc;
      if (dec_valid && dec_ready) begin
        n_fire++;
        if (exp_q.size() > 0) begin
          pc = exp_q.pop_front();
          check("dec_pc", dec_pc, pc);
          check("dec_instr", dec_instr, mem_word(pc));
        end
      end
    end
  end

  // Memory: in-order responses, each lat cycles after its accept.
  always @(posedge clk) begin : mem
    req_t r;
    #1;
    if (!rst_n) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else if (pend.size() > 0 && pend[0].tag + lat <= cyc + 1) begin
      r = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(r.addr);
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) step();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
    check("rst_dec_instr", dec_instr, 32'h0000_0013);
    check("rst_dec_pc", dec_pc, RPC);

    rst_n = 1'b1;
    push_seq(RPC, 8);
    wait_empty(100);
    check("req_addr0", acc_log[0], RPC);
    check("req_addr1", acc_log[1], RPC + 32'h4);
    check("req_addr2", acc_log[2], RPC + 32'h8);
    check("first_latency", 32'(first_dv - first_acc), 32'(FIRST_LAT));

    dec_ready = 1'b0;
    repeat (10) step();
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("stall_in_flight", 32'(n_acc - n_fire), 32'(DEPTH));
    push_seq(RPC + 32'(4 * n_fire), 6);
    dec_ready = 1'b1;
    wait_empty(100);

    dec_ready = 1'b0;
    repeat (6) step();
    lat = 3;
    redirect = 1'b1;
    redirect_pc = 32'h0000_1000;
    step();
    redirect = 1'b0;
    repeat (3) step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_2002;
    step();
    redirect = 1'b0;
    check("drain_dec_valid", {31'b0, dec_valid}, 32'h0);
    dec_ready = 1'b1;
    push_seq(32'h0000_2000, 6);
    wait_empty(100);

    dec_ready = 1'b0;
    step();
    lat = 1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF4;
    acc_log.delete();
    step();
    redirect = 1'b0;
    push_seq(32'hFFFF_FFF4, 5);
    dec_ready = 1'b1;
    wait_empty(100);
    check("wrap_addr_fc", acc_log[2], 32'hFFFF_FFFC);
    check("wrap_addr_0", acc_log[3], 32'h0000_0000);

    dec_ready = 1'b0;
    step();
    lat = 3;
    redirect = 1'b1;
    redirect_pc = 32'h0000_3000;
    step();
    redirect = 1'b0;
    repeat (3) step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_4000;
    step();
    redirect = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("mid_rst_dec_valid", {31'b0, dec_valid}, 32'h0);
    check("mid_rst_dec_instr", dec_instr, 32'h0000_0013);
    check("mid_rst_dec_pc", dec_pc, RPC);
    lat = 1;
    step();
    step();
    first_acc = -1;
    first_dv = -1;
    n_acc = 0;
    n_fire = 0;
    acc_log.delete();
    dec_ready = 1'b1;
    rst_n = 1'b1;
    push_seq(RPC, 4);
    wait_empty(100);
    check("restart_addr", acc_log[0], RPC);
    check("restart_latency", 32'(first_dv - first_acc), 32'(FIRST_LAT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Front end that produces the 32-bit instruction words the decode controller consumes.
- Issues sequential fetch requests to instruction memory and buffers in-order responses in a small queue.
- Presents {instr, pc} to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution, including discarding stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries and the maximum number of outstanding requests (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; word aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- dec_valid  out  1  dec_instr/dec_pc valid.
- dec_instr  out  32  instruction to decode.
- dec_pc  out  32  PC of dec_instr.
- dec_ready  in  1  decode consumes this cycle (0 = stall).
- redirect  in  1  flush and refetch from redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset values (async assert; release synchronised externally):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; drop = 0; state = IDLE.
  - Outputs: imem_req_valid=0, dec_valid=0, dec_instr=32'h0000_0013 (NOP), dec_pc=RESET_PC.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH unconditionally one cycle after reset release.
  - FETCH -> DRAIN on redirect while outstanding>0, counting any in-flight responses not consumed this cycle.
  - DRAIN -> FETCH when drop reaches 0.
- Request rule: imem_req_valid = (state!=IDLE) && !redirect && (count + outstanding < DEPTH).
  - Request accepted when valid && ready; fetch_pc += 4, wrapping 0xFFFF_FFFC -> 0.
  - imem_req_addr = fetch_pc, held stable while valid && !ready.
- Response rule:
  - rsp_valid with drop>0: discard, drop-1.
  - Otherwise: push {data, pc_of_request} and decrement outstanding. The PC travels with the request through an in-order tag FIFO of depth DEPTH.
  - Credit rule guarantees the queue never overflows. A push into a full queue is an assertion failure.
- Decode side:
  - dec_valid = queue non-empty; dec_instr/dec_pc = head entry.
  - Head pops when dec_valid && dec_ready.
  - When empty, dec_instr=NOP and dec_pc holds its last value.
- Latency: request accept -> response -> dec_valid on the cycle after the response (registered queue).
- Redirect (single cycle, highest priority):
  - Queue cleared at the clock edge; dec_valid=0 on the next cycle. A pop in the redirect cycle is still honoured.
  - fetch_pc = redirect_pc & ~3.
  - drop = outstanding + (req accepted this cycle ? 1 : 0) − (rsp arriving this cycle ? 1 : 0); that response is itself discarded.
  - outstanding tracks drop.
- During DRAIN, new requests to the redirect target may issue. Responses are in order, so the first `drop` responses are stale.
- A redirect during DRAIN re-adds current outstanding to drop. Stays in DRAIN.
- Simultaneous push and pop with a full queue: legal; count unchanged.
- outstanding and drop are each $clog2(DEPTH)+1 bits wide; saturation is impossible by credit rule.

Optional Feature:
- IF_BYPASS_EN, when defined:
  - Queue empty, response not dropped, no redirect: response is combinationally forwarded to dec_instr/dec_pc/dec_valid in the same cycle.
  - If dec_ready=1 it is not enqueued; otherwise it is enqueued as normal.
  - Response-to-decode latency is 0 cycles.
- Without the macro: always enqueued; 1-cycle latency.

Decomposition:
- Package rv_fetch_pkg:
  - XLEN=32, NOP_INSTR=32'h0000_0013, PC_STEP=4, fetch state enum {IDLE, FETCH, DRAIN}.
- Sub-module instr_fifo: synchronous FIFO, width and depth parameterised, with flush input and count output.
  - Instantiated twice: instruction/PC queue and request-PC tag FIFO.

Test Plan:
- Reset with RESET_PC=0x100, memory always ready with 1-cycle response -> requests 0x100, 0x104, 0x108…; dec_pc sequence matches; dec_valid first high 2 cycles after the first request accept.
- dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests outstanding/buffered; imem_req_valid drops; no data lost; resuming yields consecutive PCs.
- Memory latency 3, redirect to 0x2002 with 3 in flight -> 3 stale responses discarded; next dec_pc=0x2000 with its correct data.
- Redirect in the same cycle as a response and a request accept -> that response is discarded, drop counted correctly; no stale PC reaches decode.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000.
- rst_n asserted mid-DRAIN -> all outputs return to reset values immediately; fetch restarts at RESET_PC; with IF_BYPASS_EN, first dec_valid arrives the same cycle as the first response.
